// File: rtl/data_mem_responder.sv
// data_mem_responder: waits WAIT_STATES cycles, then services word/byte load/store/swap on internal RAM; ports req/wr/byte/swp/addr/wdata in, busy/ack/rdata/abort out
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic        wr_in,
  input  logic        byte_in,
  input  logic        swp_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy_out,
  output logic        ack_out,
  output logic [31:0] rdata_out,
  output logic        abort_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, SWP_WR, DONE} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, rd, rot, ld_data;
  logic wr_q, byte_q, swp_q, abort_q, in_range, do_wr;
  logic [4:0] sh;
  logic [31:0] mem [DEPTH_WORDS];
  assign in_range = addr_q[31:AW+2] == '0;
  assign rd = mem[addr_q[AW+1:2]];
  assign sh = {addr_q[1:0], 3'b000};
  assign rot = (rd >> sh) | (rd << (6'd32 - {1'b0, sh}));
  assign ld_data = byte_q ? {24'b0, rot[7:0]} : rot;
  assign busy_out = state != IDLE;
  assign ack_out = state == DONE;
  assign abort_out = ack_out & abort_q;
  always_comb begin
    next = IDLE;
    do_wr = 1'b0;
    unique case (state)
      IDLE:    next = req_in ? (WAIT_STATES > 0 ? WAIT : ACCESS) : IDLE;
      WAIT:    next = cnt == 4'd0 ? ACCESS : WAIT;
      ACCESS:  next = (swp_q && in_range) ? SWP_WR : DONE;
      SWP_WR:  next = DONE;
      default: next = IDLE;
    endcase
    do_wr = !rst_in && in_range && ((state == ACCESS && wr_q && !swp_q) || state == SWP_WR);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata_out <= 32'd0;
      abort_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && req_in) begin
        addr_q <= addr_in;
        wdata_q <= wdata_in;
        wr_q <= wr_in;
        byte_q <= byte_in;
        swp_q <= swp_in;
        cnt <= WS_M1;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == ACCESS) begin
        abort_q <= !in_range;
        if (!in_range) rdata_out <= 32'd0;
        else if (swp_q || !wr_q) rdata_out <= ld_data;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 4; i++)
      if (do_wr && (!byte_q || addr_q[1:0] == 2'(i)))
        mem[addr_q[AW+1:2]][8*i +: 8] <= byte_q ? wdata_q[7:0] : wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed load/store/swap/abort/reset checks against a word-array reference model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int WS = 1;
  logic clk = 0, rst = 1, req = 0, wr = 0, byt = 0, swp = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic busy, ack, abort;
  logic [31:0] mdl [64];
  logic [31:0] last = 0, got;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .wr_in(wr), .byte_in(byt), .swp_in(swp),
    .addr_in(addr), .wdata_in(wdata), .busy_out(busy), .ack_out(ack), .rdata_out(rdata), .abort_out(abort)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] a, input bit b);
    logic [63:0] d;
    d = {mdl[a[7:2]], mdl[a[7:2]]} >> (8 * int'(a[1:0]));
    return b ? (d[31:0] & 32'hFF) : d[31:0];
  endfunction
  task automatic ref_store(input logic [31:0] a, input bit b, input logic [31:0] d);
    if (b) mdl[a[7:2]][8*int'(a[1:0]) +: 8] = d[7:0];
    else mdl[a[7:2]] = d;
  endtask
  task automatic op(input string tag, input bit w, b, s, input logic [31:0] a, d, input bit pulse, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit oor;
    int exp_lat, lat;
    oor = a >= 32'(4 * DEPTH);
    exp_lat = WS + 1 + ((s && !oor) ? 1 : 0);
    exp_rd = oor ? 32'd0 : (s || !w) ? ref_load(a, b) : last;
    @(negedge clk);
    req = 1; wr = w; byt = b; swp = s; addr = a; wdata = d;
    @(negedge clk);
    req = 0; addr = $urandom; wdata = $urandom; wr = $urandom; byt = $urandom; swp = $urandom;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!ack && lat < 50) begin
      if (pulse && lat == 1) req = 1;
      @(negedge clk);
      req = 0;
      lat++;
    end
    rd = rdata;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_abort"}, 32'(abort), 32'(oor));
    chk({tag, "_rdata"}, rdata, exp_rd);
    @(negedge clk);
    chk({tag, "_ackpulse"}, {30'd0, ack, busy}, 32'd0);
    if (!oor && (s || w)) ref_store(a, b, d);
    last = exp_rd;
  endtask
  initial begin
    int acks;
    repeat (3) @(negedge clk);
    chk("rst_outs", {28'd0, busy, ack, abort, 1'b0}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 0;
    for (int i = 0; i < 64; i++) mdl[i] = 0;
    for (int i = 0; i < 64; i++) op("init", 1, 0, 0, 32'(4 * i), 32'd0, 0, got);
    op("st10", 1, 0, 0, 32'h10, 32'hDEADBEEF, 0, got);
    op("ld10", 0, 0, 0, 32'h10, 0, 0, got);
    chk("plan_ld10", got, 32'hDEADBEEF);
    op("ld11", 0, 0, 0, 32'h11, 0, 0, got);
    chk("plan_ld11", got, 32'hEFDEADBE);
    op("ld13", 0, 0, 0, 32'h13, 0, 0, got);
    chk("plan_ld13", got, 32'hADBEEFDE);
    op("stb12", 1, 1, 0, 32'h12, 32'h55, 0, got);
    op("ldb12", 0, 1, 0, 32'h12, 0, 0, got);
    chk("plan_ldb12", got, 32'h55);
    op("ld10b", 0, 0, 0, 32'h10, 0, 0, got);
    chk("plan_ld10b", got, 32'hDE55BEEF);
    op("swp10", 0, 0, 1, 32'h10, 32'h12345678, 1, got);
    chk("plan_swp", got, 32'hDE55BEEF);
    acks = 0;
    repeat (4) begin @(negedge clk); acks += int'(ack); end
    chk("swp_no_second_ack", 32'(acks), 32'd0);
    op("ld10c", 0, 0, 0, 32'h10, 0, 0, got);
    chk("plan_ld10c", got, 32'h12345678);
    op("st_oor", 1, 0, 0, 32'h1000, 32'hAAAA5555, 0, got);
    op("ld_oor", 0, 0, 0, 32'h1000, 0, 0, got);
    chk("plan_ld_oor", got, 32'd0);
    op("ld0", 0, 0, 0, 32'h0, 0, 0, got);
    chk("plan_ld0", got, 32'd0);
    @(negedge clk);
    req = 1; wr = 1; byt = 0; swp = 0; addr = 32'h20; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req = 0;
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_idle", {30'd0, busy, ack}, 32'd0);
    acks = 0;
    repeat (4) begin @(negedge clk); acks += int'(ack); end
    chk("rst_mid_noack", 32'(acks), 32'd0);
    last = 0;
    op("ld20", 0, 0, 0, 32'h20, 0, 0, got);
    chk("plan_ld20", got, 32'd0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 3);
      a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'h7FFF0000) : 32'($urandom_range(0, 255));
      op("rnd", k == 1, $urandom_range(0, 1) == 1, k == 2, a, $urandom, $urandom_range(0, 3) == 0, got);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
